// File: rtl/change_pkg.sv
// Shared types and constants for the vending change path:
// coin encodings, dispense codes, coin values and FSM states.
package change_pkg;

  typedef enum logic [1:0] {
    COIN_NONE     = 2'b00,
    COIN_CIRCLE   = 2'b01,
    COIN_TRIANGLE = 2'b10,
    COIN_PENTAGON = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQUEST = 2'd2
  } state_t;

  localparam logic [2:0] DISP_NONE = 3'b000;
  localparam logic [2:0] DISP_CIRC = 3'b001;
  localparam logic [2:0] DISP_TRI  = 3'b010;
  localparam logic [2:0] DISP_PENT = 3'b011;

  localparam logic [2:0] VAL_CIRC = 3'd1;
  localparam logic [2:0] VAL_TRI  = 3'd3;
  localparam logic [2:0] VAL_PENT = 3'd5;

  function automatic logic [2:0] coin_value(coin_t c);
    case (c)
      COIN_CIRCLE:   return VAL_CIRC;
      COIN_TRIANGLE: return VAL_TRI;
      COIN_PENTAGON: return VAL_PENT;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] hits(
    logic [2:0] a, logic [2:0] b, logic [2:0] code
  );
    return {1'b0, a == code} + {1'b0, b == code};
  endfunction

  function automatic logic [1:0] drop(logic [1:0] c, logic [1:0] dn);
    return (dn > c) ? 2'd0 : c - dn;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three 2-bit coin counters: +1 on an accepted coin,
// up to -2 on a dispense, flooring at zero.
module coin_inventory
  import change_pkg::*;
#(
  parameter logic [1:0] INIT_PENT = 2'd1,
  parameter logic [1:0] INIT_TRI  = 2'd1,
  parameter logic [1:0] INIT_CIRC = 2'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  coin_t      inc_type,
  input  logic       dec,
  input  logic [2:0] first_coin,
  input  logic [2:0] second_coin,
  output logic [1:0] pentagons,
  output logic [1:0] triangles,
  output logic [1:0] circles,
  output logic       full
);

  logic [1:0] pent_dn;
  logic [1:0] tri_dn;
  logic [1:0] circ_dn;

  always_comb begin
    pent_dn = 2'd0;
    tri_dn  = 2'd0;
    circ_dn = 2'd0;
    if (dec) begin
      pent_dn = hits(first_coin, second_coin, DISP_PENT);
      tri_dn  = hits(first_coin, second_coin, DISP_TRI);
      circ_dn = hits(first_coin, second_coin, DISP_CIRC);
    end
  end

  always_comb begin
    full = 1'b0;
    case (inc_type)
      COIN_CIRCLE:   full = (circles == 2'd3);
      COIN_TRIANGLE: full = (triangles == 2'd3);
      COIN_PENTAGON: full = (pentagons == 2'd3);
      default:       full = 1'b0;
    endcase
  end

  // inc and dec are never both active: they belong to different states
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pentagons <= INIT_PENT;
      triangles <= INIT_TRI;
      circles   <= INIT_CIRC;
    end else begin
      if (inc && !full && inc_type == COIN_PENTAGON)
        pentagons <= pentagons + 2'd1;
      else
        pentagons <= drop(pentagons, pent_dn);
      if (inc && !full && inc_type == COIN_TRIANGLE)
        triangles <= triangles + 2'd1;
      else
        triangles <= drop(triangles, tri_dn);
      if (inc && !full && inc_type == COIN_CIRCLE)
        circles <= circles + 2'd1;
      else
        circles <= drop(circles, circ_dn);
    end
  end

endmodule

// File: rtl/payment_collector.sv
// Vending transaction front end: collects coins, then holds a
// stable change request until acknowledged.
module payment_collector
  import change_pkg::*;
#(
  parameter logic [1:0] INIT_PENT = 2'd1,
  parameter logic [1:0] INIT_TRI  = 2'd1,
  parameter logic [1:0] INIT_CIRC = 2'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cost_in,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       change_ack,
  input  logic [2:0] first_coin,
  input  logic [2:0] second_coin,
  output logic [3:0] Cost,
  output logic [3:0] Paid,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic       change_req,
  output logic       busy,
  output logic       coin_reject
);

  state_t     state;
  state_t     state_nxt;
  coin_t      ctype;
  logic       full;
  logic       coin_ok;
  logic       ack_ok;
  logic [4:0] sum;
  logic [3:0] paid_add;
  logic [3:0] paid_nxt;
  logic [3:0] cost_nxt;

  assign ctype   = coin_t'(coin_type);
  assign coin_ok = (state == ST_COLLECT) && coin_valid &&
                   (ctype != COIN_NONE) && !full;
  assign ack_ok  = (state == ST_REQUEST) && change_ack;

  assign sum      = {1'b0, Paid} + {2'b00, coin_value(ctype)};
  assign paid_add = sum[4] ? 4'hF : sum[3:0];

  always_comb begin
    state_nxt = state;
    cost_nxt  = Cost;
    paid_nxt  = Paid;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cost_nxt  = cost_in;
          paid_nxt  = 4'd0;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (coin_ok) paid_nxt = paid_add;
        // cancel zeroes the price so the full payment is refunded
        if (cancel) begin
          cost_nxt  = 4'd0;
          state_nxt = ST_REQUEST;
        end else if (paid_nxt >= Cost) begin
          state_nxt = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (change_ack) begin
          paid_nxt  = 4'd0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      Cost        <= 4'd0;
      Paid        <= 4'd0;
      change_req  <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      Cost        <= cost_nxt;
      Paid        <= paid_nxt;
      change_req  <= (state_nxt == ST_REQUEST);
      busy        <= (state_nxt != ST_IDLE);
      coin_reject <= coin_valid && !coin_ok;
    end
  end

  coin_inventory #(
    .INIT_PENT(INIT_PENT),
    .INIT_TRI (INIT_TRI),
    .INIT_CIRC(INIT_CIRC)
  ) u_inv (
    .clock      (clock),
    .reset      (reset),
    .inc        (coin_ok),
    .inc_type   (ctype),
    .dec        (ack_ok),
    .first_coin (first_coin),
    .second_coin(second_coin),
    .pentagons  (Pentagons),
    .triangles  (Triangles),
    .circles    (Circles),
    .full       (full)
  );

endmodule
